magnetron_latch_driver: RTL

Synchronous controller that drives the set/reset inputs of the magnetron SR latch. It converts the microwave control events (start, stop/clear, door state, cook timer expiry) into clean, mutually exclusive, fixed-width set and reset pulses. It also enforces a minimum magnetron off-time before any re-ignition. It sits between the cook-timer/keypad logic and the magnetron latch.

---
 rtl/magnetron_pkg.sv | 30 +++
 rtl/mag_pulse_timer.sv | 26 ++
 rtl/magnetron_latch_driver.sv | 107 ++++++++++
 3 files changed

// File: rtl/magnetron_pkg.sv
// magnetron_pkg: shared types and defaults for the magnetron latch driver.
//   mag_state_t : controller states
//   mag_out_t   : registered output bundle driven toward the latch
//   imax        : helper for sizing the shared down-counter
package magnetron_pkg;

   typedef enum logic [2:0] {
      BOOT        = 3'd0,
      RESET_PULSE = 3'd1,
      COOLDOWN    = 3'd2,
      IDLE        = 3'd3,
      SET_PULSE   = 3'd4,
      ON          = 3'd5
   } mag_state_t;

   typedef struct packed {
      logic set;
      logic reset;
      logic on;
      logic busy;
   } mag_out_t;

   localparam int MAG_PULSE_CYCLES   = 4;
   localparam int MAG_MIN_OFF_CYCLES = 10;

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/mag_pulse_timer.sv
// mag_pulse_timer: loadable down-counter that saturates at zero.
//   clk, rst_n : clock, async active-low reset (value -> 0)
//   load       : load load_val on this edge (wins over decrement)
//   load_val   : value to load
//   value      : current count
//   zero       : value == 0
module mag_pulse_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] value,
   output logic         zero
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           value <= '0;
      else if (load)        value <= load_val;
      else if (value != '0) value <= value - 1'b1;
   end

   assign zero = (value == '0);

endmodule

// File: rtl/magnetron_latch_driver.sv
// magnetron_latch_driver: turns start/stop/door/timer events into clean,
// mutually exclusive fixed-width set/reset pulses for the magnetron SR latch
// and enforces a minimum off-time before re-ignition.
//   clk, rst_n   : clock, async active-low reset
//   start        : level, request magnetron on
//   stop         : level, stop/clear
//   door_closed  : level, 1 = door closed and latched
//   timer_done   : level, cook timer expired
//   mag_set      : latch S (registered)
//   mag_reset    : latch R (registered)
//   mag_on       : magnetron commanded on (SET_PULSE or ON)
//   busy         : any state other than IDLE
module magnetron_latch_driver
   import magnetron_pkg::*;
#(
   parameter int PULSE_CYCLES   = MAG_PULSE_CYCLES,
   parameter int MIN_OFF_CYCLES = MAG_MIN_OFF_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic stop,
   input  logic door_closed,
   input  logic timer_done,
   output logic mag_set,
   output logic mag_reset,
   output logic mag_on,
   output logic busy
);

   localparam int CNT_W = $clog2(imax(PULSE_CYCLES, MIN_OFF_CYCLES) + 1);

   mag_state_t       state_q, state_d;
   mag_out_t         out_d, out_q;
   logic             kill;
   logic             cnt_load, cnt_zero;
   logic [CNT_W-1:0] cnt_load_val, cnt_val;
   logic             unused_cnt;

   assign kill = stop | timer_done | ~door_closed;

   // State and output registers. Outputs are decoded from the next state and
   // registered so the latch never sees a combinational glitch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BOOT;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
      end
   end

   // Next-state logic. Timed states leave when the shared counter hits zero;
   // it was loaded with (duration-1) on entry.
   always_comb begin
      state_d = state_q;
      case (state_q)
         BOOT:        state_d = RESET_PULSE;
         RESET_PULSE: if (cnt_zero) state_d = COOLDOWN;
         COOLDOWN:    if (cnt_zero) state_d = IDLE;
         IDLE:        if (start && !kill) state_d = SET_PULSE;
         SET_PULSE: begin
            if (kill)          state_d = RESET_PULSE;
            else if (cnt_zero) state_d = ON;
         end
         ON:          if (kill) state_d = RESET_PULSE;
         default:     state_d = RESET_PULSE;
      endcase
   end

   // Counter load on entry to any timed state.
   always_comb begin
      cnt_load     = (state_d != state_q) &&
                     (state_d == RESET_PULSE || state_d == COOLDOWN ||
                      state_d == SET_PULSE);
      cnt_load_val = (state_d == COOLDOWN) ? CNT_W'(MIN_OFF_CYCLES - 1)
                                           : CNT_W'(PULSE_CYCLES - 1);
   end

   // Output decode from next state; set and reset are one-hot by construction.
   always_comb begin
      out_d       = '0;
      out_d.set   = (state_d == SET_PULSE);
      out_d.reset = (state_d == RESET_PULSE);
      out_d.on    = (state_d == SET_PULSE) || (state_d == ON);
      out_d.busy  = (state_d != IDLE);
   end

   mag_pulse_timer #(.W(CNT_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .value    (cnt_val),
      .zero     (cnt_zero)
   );

   // Only the zero flag drives the FSM; the raw count is observability only.
   assign unused_cnt = ^cnt_val;

   assign mag_set   = out_q.set;
   assign mag_reset = out_q.reset;
   assign mag_on    = out_q.on;
   assign busy      = out_q.busy;

endmodule
